difftest_clk_step_ctrl: RTL and testbench

- Generates the `data_next` clock-enable that the FPGA clock-gating stage uses to gate the SoC, device and timer clocks.
- Runs on the free-running FPGA clock and takes run/step/stop commands from the host-side control path.
- Throttles the DUT when the downstream difftest packet buffer nears full.
- Freezes the DUT on a trap indication.

---
 rtl/difftest_clk_step_ctrl_if.sv | 24 ++
 rtl/difftest_clk_step_ctrl.sv | 162 ++++++++++++++++
 tb/tb_difftest_clk_step_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/difftest_clk_step_ctrl_if.sv
// Host-side command channel for the difftest clock step controller.
// The host drives the master side and the controller consumes commands on the slave side.
interface difftest_clk_step_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cycles;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_cycles,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_cycles,
    output cmd_ready
  );
endinterface

// File: rtl/difftest_clk_step_ctrl.sv
// Produces the registered data_next clock enable that gates the SoC, device and timer clocks.
// Handles host run/step/stop commands, buffer backpressure (HOLD) and trap freezes (HALT).
module difftest_clk_step_ctrl #(
  parameter int CNT_W        = 32,
  parameter int RESUME_DELAY = 4,
  parameter int STALL_W      = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  difftest_clk_step_ctrl_if.slave cmd,
  input  logic                   buf_almost_full,
  input  logic                   trap_i,
  output logic                   data_next,
  output logic [2:0]             state_o,
  output logic                   done,
  output logic                   cmd_err,
  output logic [63:0]            cycle_count,
  output logic [STALL_W-1:0]     stall_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STEP = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam int                 RES_W     = $clog2(RESUME_DELAY + 1);
  localparam logic [RES_W-1:0]   RES_LIMIT = RES_W'(RESUME_DELAY);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  state_e             state_q, state_d;
  state_e             saved_q, saved_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [RES_W-1:0]   resume_q, resume_d;
  logic               data_next_q, data_next_d;
  logic               done_q, done_d;
  logic               cmd_err_q, cmd_err_d;
  logic [63:0]        cycle_count_q, cycle_count_d;
  logic [STALL_W-1:0] stall_count_q, stall_count_d;
  logic               active;

  // Priority chain: trap, then command, then STEP termination, then backpressure / resume.
  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    remaining_d   = remaining_q;
    resume_d      = resume_q;
    done_d        = 1'b0;
    cmd_err_d     = 1'b0;
    cycle_count_d = cycle_count_q + (data_next_q ? 64'd1 : 64'd0);
    stall_count_d = stall_count_q;
    active        = (state_q == ST_STEP) || (state_q == ST_RUN) || (state_q == ST_HOLD);

    if ((state_q == ST_HOLD) && (stall_count_q != STALL_MAX)) begin
      stall_count_d = stall_count_q + STALL_W'(1);
    end
    if (state_q == ST_STEP) begin
      remaining_d = remaining_q - CNT_W'(1);
    end

    if (trap_i && active) begin
      state_d = ST_HALT;
      done_d  = 1'b1;
    end else if (cmd.cmd_valid) begin
      case (cmd.cmd_op)
        OP_CLEAR: begin
          state_d       = ST_IDLE;
          remaining_d   = '0;
          resume_d      = '0;
          cycle_count_d = '0;
          stall_count_d = '0;
        end
        OP_STOP: begin
          if (active) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            done_d      = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_STEP: begin
          if (state_q != ST_IDLE) begin
            cmd_err_d = 1'b1;
          end else if (cmd.cmd_cycles == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_STEP;
            remaining_d = cmd.cmd_cycles;
          end
        end
        default: begin
          if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end else if ((state_q == ST_STEP) && (remaining_q == CNT_W'(1))) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      done_d      = 1'b1;
    end else if (data_next_q && buf_almost_full) begin
      state_d  = ST_HOLD;
      saved_d  = state_q;
      resume_d = '0;
    end else if (state_q == ST_HOLD) begin
      // Leave HOLD only once the low-streak counter has reached the limit.
      if (resume_q == RES_LIMIT) begin
        state_d  = saved_q;
        resume_d = '0;
      end else if (buf_almost_full) begin
        resume_d = '0;
      end else begin
        resume_d = resume_q + RES_W'(1);
      end
    end

    data_next_d = (state_d == ST_STEP) || (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      saved_q       <= ST_IDLE;
      remaining_q   <= '0;
      resume_q      <= '0;
      data_next_q   <= 1'b0;
      done_q        <= 1'b0;
      cmd_err_q     <= 1'b0;
      cycle_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      saved_q       <= saved_d;
      remaining_q   <= remaining_d;
      resume_q      <= resume_d;
      data_next_q   <= data_next_d;
      done_q        <= done_d;
      cmd_err_q     <= cmd_err_d;
      cycle_count_q <= cycle_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign cmd.cmd_ready = 1'b1;
  assign data_next     = data_next_q;
  assign state_o       = state_q;
  assign done          = done_q;
  assign cmd_err       = cmd_err_q;
  assign cycle_count   = cycle_count_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_difftest_clk_step_ctrl.sv
// Scoreboard bench for difftest_clk_step_ctrl: directed scenarios followed by random traffic,
// every cycle's outputs compared against a behavioural reference model.
module tb_difftest_clk_step_ctrl;

  localparam int RESUME_DELAY = 4;
  localparam int S_IDLE = 0, S_STEP = 1, S_RUN = 2, S_HOLD = 3, S_HALT = 4;
  localparam bit [1:0] OP_STOP = 2'd0, OP_STEP = 2'd1, OP_RUN = 2'd2, OP_CLEAR = 2'd3;

  logic        clock;
  logic        reset;
  logic        bufAlmostFull;
  logic        trap;
  logic        dataNext;
  logic [2:0]  stateOut;
  logic        doneOut;
  logic        cmdErr;
  logic [63:0] cycleCount;
  logic [31:0] stallCount;

  difftest_clk_step_ctrl_if #(.CNT_W(32)) cmdIf ();

  difftest_clk_step_ctrl #(
    .CNT_W(32),
    .RESUME_DELAY(RESUME_DELAY),
    .STALL_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd(cmdIf),
    .buf_almost_full(bufAlmostFull),
    .trap_i(trap),
    .data_next(dataNext),
    .state_o(stateOut),
    .done(doneOut),
    .cmd_err(cmdErr),
    .cycle_count(cycleCount),
    .stall_count(stallCount)
  );

  typedef struct {
    bit          dataNext;
    bit [2:0]    state;
    bit          done;
    bit          err;
    bit [63:0]   cycles;
    bit [31:0]   stalls;
  } expT;

  expT expQ[$];
  int  compared = 0;
  int  failed   = 0;

  // Reference model state, kept in plain integers.
  int          mState  = S_IDLE;
  int          mSaved  = S_IDLE;
  int          mLowRun = 0;
  longint      mLeft   = 0;
  bit [63:0]   mCycles = 0;
  bit [31:0]   mStalls = 0;
  bit          mDone   = 0;
  bit          mErr    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of the model: what the block must show after consuming these inputs.
  task automatic modelStep(input bit rst, input bit valid, input bit [1:0] op,
                           input bit [31:0] n, input bit baf, input bit trp);
    bit enabled;
    bit busy;
    int prev;
    prev    = mState;
    enabled = (prev == S_STEP) || (prev == S_RUN);
    busy    = enabled || (prev == S_HOLD);
    mDone   = 0;
    mErr    = 0;
    if (rst) begin
      mState = S_IDLE; mSaved = S_IDLE; mLowRun = 0; mLeft = 0; mCycles = 0; mStalls = 0;
      return;
    end
    if (enabled) mCycles = mCycles + 1;
    if (prev == S_HOLD && mStalls != 32'hFFFF_FFFF) mStalls = mStalls + 1;
    if (prev == S_STEP) mLeft = mLeft - 1;
    if (trp && busy) begin
      mState = S_HALT;
      mDone  = 1;
      return;
    end
    if (valid) begin
      if (op == OP_CLEAR) begin
        mState = S_IDLE; mLeft = 0; mLowRun = 0; mCycles = 0; mStalls = 0;
      end else if (op == OP_STOP) begin
        if (busy) begin mState = S_IDLE; mLeft = 0; mDone = 1; end
        else mErr = 1;
      end else if (op == OP_STEP) begin
        if (prev != S_IDLE) mErr = 1;
        else if (n == 0) mDone = 1;
        else begin mState = S_STEP; mLeft = longint'(n); end
      end else begin
        if (prev == S_IDLE) mState = S_RUN;
        else mErr = 1;
      end
      return;
    end
    if (prev == S_STEP && mLeft == 0) begin
      mState = S_IDLE;
      mDone  = 1;
    end else if (enabled && baf) begin
      mState  = S_HOLD;
      mSaved  = prev;
      mLowRun = 0;
    end else if (prev == S_HOLD) begin
      if (mLowRun == RESUME_DELAY) begin
        mState  = mSaved;
        mLowRun = 0;
      end else begin
        mLowRun = baf ? 0 : mLowRun + 1;
      end
    end
  endtask

  // Drive one cycle of inputs, record the expected response, return at the following negedge.
  task automatic applyStimulus(input bit rst, input bit valid, input bit [1:0] op,
                               input bit [31:0] n, input bit baf, input bit trp);
    expT e;
    reset            = rst;
    cmdIf.cmd_valid  = valid;
    cmdIf.cmd_op     = op;
    cmdIf.cmd_cycles = n;
    bufAlmostFull    = baf;
    trap             = trp;
    modelStep(rst, valid, op, n, baf, trp);
    e.dataNext = (mState == S_STEP) || (mState == S_RUN);
    e.state    = 3'(mState);
    e.done     = mDone;
    e.err      = mErr;
    e.cycles   = mCycles;
    e.stalls   = mStalls;
    expQ.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input int cycles, input bit baf);
    for (int i = 0; i < cycles; i++) applyStimulus(0, 0, OP_STOP, 0, baf, 0);
  endtask

  task automatic command(input bit [1:0] op, input bit [31:0] n, input bit baf);
    applyStimulus(0, 1, op, n, baf, 0);
  endtask

  // Monitor: pops one expectation per clock, once the DUT has registered that cycle.
  initial begin
    expT e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("data_next",   64'(dataNext),      64'(e.dataNext));
        checkOutput("state_o",     64'(stateOut),      64'(e.state));
        checkOutput("done",        64'(doneOut),       64'(e.done));
        checkOutput("cmd_err",     64'(cmdErr),        64'(e.err));
        checkOutput("cycle_count", cycleCount,         e.cycles);
        checkOutput("stall_count", 64'(stallCount),    64'(e.stalls));
        checkOutput("cmd_ready",   64'(cmdIf.cmd_ready), 64'd1);
      end
    end
  end

  initial begin
    bit baf;
    bit valid;
    bit [1:0] op;

    applyStimulus(1, 0, OP_STOP, 0, 0, 0);
    applyStimulus(1, 0, OP_STOP, 0, 0, 0);
    checkOutput("resetState", 64'(stateOut), 64'd0);
    checkOutput("resetDataNext", 64'(dataNext), 64'd0);
    idle(7, 0);

    // STEP 5: five enabled cycles, then done, then quiet IDLE.
    command(OP_STEP, 5, 0);
    idle(5, 0);
    checkOutput("step5Done", 64'(doneOut), 64'd1);
    idle(1, 0);
    checkOutput("step5Cycles", cycleCount, 64'd5);
    checkOutput("step5State", 64'(stateOut), 64'd0);

    // RUN with a 10-cycle backpressure burst: 14 HOLD cycles before resuming.
    command(OP_CLEAR, 0, 0);
    command(OP_RUN, 0, 0);
    idle(9, 0);
    idle(10, 1);
    idle(5, 0);
    checkOutput("holdStalls", 64'(stallCount), 64'd14);
    checkOutput("holdResumed", 64'(dataNext), 64'd1);
    command(OP_STOP, 0, 1);
    checkOutput("stopWithBafState", 64'(stateOut), 64'd0);
    checkOutput("stopWithBafDone", 64'(doneOut), 64'd1);

    // STEP 10 interrupted at its fourth enabled cycle.
    command(OP_CLEAR, 0, 0);
    command(OP_STEP, 10, 0);
    idle(3, 0);
    idle(1, 1);
    idle(20, 0);
    checkOutput("step10Cycles", cycleCount, 64'd10);
    checkOutput("step10State", 64'(stateOut), 64'd0);

    // Trap during RUN, then a rejected RUN, then CLEAR.
    command(OP_RUN, 0, 0);
    idle(5, 0);
    applyStimulus(0, 0, OP_STOP, 0, 0, 1);
    checkOutput("trapState", 64'(stateOut), 64'd4);
    checkOutput("trapDone", 64'(doneOut), 64'd1);
    command(OP_RUN, 0, 0);
    checkOutput("haltRunErr", 64'(cmdErr), 64'd1);
    command(OP_CLEAR, 0, 0);
    checkOutput("clearCycles", cycleCount, 64'd0);
    checkOutput("clearState", 64'(stateOut), 64'd0);

    // STEP 0, RUN while running, reset mid-STEP.
    command(OP_STEP, 0, 0);
    checkOutput("step0Done", 64'(doneOut), 64'd1);
    command(OP_RUN, 0, 0);
    command(OP_RUN, 0, 0);
    checkOutput("runRunErr", 64'(cmdErr), 64'd1);
    checkOutput("runRunState", 64'(stateOut), 64'd2);
    command(OP_STOP, 0, 0);
    command(OP_STEP, 20, 0);
    idle(13, 0);
    applyStimulus(1, 0, OP_STOP, 0, 0, 0);
    checkOutput("midResetDataNext", 64'(dataNext), 64'd0);
    checkOutput("midResetCycles", cycleCount, 64'd0);
    checkOutput("midResetDone", 64'(doneOut), 64'd0);

    // Random traffic with bursty backpressure.
    baf = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 10) baf = !baf;
      valid = ($urandom_range(0, 99) < 12);
      op    = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 999) < 4, valid, op, 32'($urandom_range(0, 12)), baf,
                    !valid && ($urandom_range(0, 99) < 2));
    end

    idle(3, 0);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
